// File: rtl/enoc_switch_allocator.sv
// Switch allocator for a 5-port ENoC router: one round-robin arbiter per
// output, combinational input acks and a registered crossbar select.
module enoc_switch_allocator #(
    parameter int N_PORTS = 5,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [0:N_PORTS-1][0:N_PORTS-1] i_req,
    input  logic [0:N_PORTS-1]              i_en,
    output logic [0:N_PORTS-1]              o_ack,
    output logic [0:N_PORTS-1][SEL_W-1:0]   o_sel,
    output logic [0:N_PORTS-1]              o_sel_val,
    output logic                            o_err
);

    logic [0:N_PORTS-1][SEL_W-1:0]   ptr;
    logic [0:N_PORTS-1][0:N_PORTS-1] req_q;
    logic [0:N_PORTS-1]              gnt_val;
    logic [0:N_PORTS-1][SEL_W-1:0]   gnt_idx;
    logic                            err_now;
    logic [SEL_W:0]                  idx;

    // A multi-hot row drops all of that input's requests; U-turns drop alone.
    always_comb begin
        req_q   = '0;
        err_now = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if ($countones(i_req[i]) > 1) begin
                err_now = 1'b1;
            end else begin
                if (i_req[i][i]) err_now = 1'b1;
                req_q[i]    = i_req[i];
                req_q[i][i] = 1'b0;
            end
        end
    end

    always_comb begin
        gnt_val = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            for (int k = 0; k < N_PORTS; k++) begin
                idx = {1'b0, ptr[o]} + (SEL_W+1)'(k);
                if (idx >= (SEL_W+1)'(N_PORTS))
                    idx = idx - (SEL_W+1)'(N_PORTS);
                if (i_en[o] && !gnt_val[o] && req_q[idx[SEL_W-1:0]][o]) begin
                    gnt_val[o] = 1'b1;
                    gnt_idx[o] = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        o_ack = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (reset_n && gnt_val[o]) o_ack[gnt_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            o_sel     <= '0;
            o_sel_val <= '0;
            o_err     <= 1'b0;
        end else begin
            o_err     <= o_err | err_now;
            o_sel_val <= gnt_val;
            for (int o = 0; o < N_PORTS; o++) begin
                if (gnt_val[o]) begin
                    o_sel[o] <= gnt_idx[o];
                    ptr[o]   <= (gnt_idx[o] == SEL_W'(N_PORTS-1)) ?
                                '0 : gnt_idx[o] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Bench for enoc_switch_allocator: per-cycle reference model compare
// plus directed scenarios with literal expectations.
module tb_enoc_switch_allocator;

    localparam int N = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [0:N-1][0:N-1] i_req = '0;
    logic [0:N-1]        i_en = '0;
    logic [0:N-1]        o_ack;
    logic [0:N-1][2:0]   o_sel;
    logic [0:N-1]        o_sel_val;
    logic                o_err;

    int n_vec = 0;
    int n_err = 0;

    int m_ptr [N];
    int m_sel [N];
    bit m_val [N];
    bit m_err;

    enoc_switch_allocator #(.N_PORTS(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_en      (i_en),
        .o_ack     (o_ack),
        .o_sel     (o_sel),
        .o_sel_val (o_sel_val),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: winner of each output is the qualified requester at
    // the smallest circular distance from that output's pointer.
    always @(negedge clk) begin
        logic [0:N-1] e_ack;
        int win [N];
        int bd, d;
        bit nerr;
        if (!reset_n) begin
            chk("rst_ack", o_ack, 0);
            chk("rst_val", o_sel_val, 0);
            chk("rst_err", o_err, 0);
            for (int o = 0; o < N; o++) begin
                m_ptr[o] = 0;
                m_sel[o] = 0;
                m_val[o] = 0;
            end
            m_err = 0;
        end else begin
            e_ack = '0;
            nerr  = 0;
            for (int i = 0; i < N; i++)
                if ($countones(i_req[i]) > 1 || i_req[i][i]) nerr = 1;
            for (int o = 0; o < N; o++) begin
                win[o] = -1;
                bd = N;
                if (i_en[o]) begin
                    for (int i = 0; i < N; i++) begin
                        if ($countones(i_req[i]) == 1 && i_req[i][o] && i != o) begin
                            d = (i - m_ptr[o] + N) % N;
                            if (d < bd) begin
                                bd = d;
                                win[o] = i;
                            end
                        end
                    end
                end
                if (win[o] >= 0) e_ack[win[o]] = 1'b1;
            end
            chk("ack", o_ack, e_ack);
            chk("err", o_err, m_err);
            for (int o = 0; o < N; o++) begin
                chk("sel_val", o_sel_val[o], m_val[o]);
                chk("sel", o_sel[o], m_sel[o]);
            end
            for (int o = 0; o < N; o++) begin
                m_val[o] = (win[o] >= 0);
                if (win[o] >= 0) begin
                    m_sel[o] = win[o];
                    m_ptr[o] = (win[o] + 1) % N;
                end
            end
            m_err = m_err | nerr;
        end
    end

    initial begin
        int seq [5];
        int seq2 [3];
        logic [0:N-1] v;
        seq  = '{0, 1, 3, 4, 0};
        seq2 = '{1, 3, 4};

        // reset held with everything asserted
        i_req   = '1;
        i_en    = '1;
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t1_ack", o_ack, 0);
            chk("t1_val", o_sel_val, 0);
            chk("t1_err", o_err, 0);
        end
        tick();
        i_req   = '0;
        reset_n = 1'b1;
        tick();

        // contention on output 2
        for (int i = 0; i < N; i++) if (i != 2) i_req[i][2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            v = '0;
            v[seq[k]] = 1'b1;
            chk("t2_ack", o_ack, v);
            if (k > 0) chk("t2_sel2", o_sel[2], seq[k-1]);
            tick();
        end

        // backpressure freezes output 2
        i_en[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_ack", o_ack, 0);
            if (k > 0) chk("t3_val2", o_sel_val[2], 0);
            tick();
        end
        i_en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v = '0;
            v[seq2[k]] = 1'b1;
            chk("t3_ack_resume", o_ack, v);
            if (k == 0) begin
                chk("t3_val2_hold", o_sel_val[2], 0);
                chk("t3_sel2_hold", o_sel[2], 0);
            end else begin
                chk("t3_sel2", o_sel[2], seq2[k-1]);
            end
            tick();
        end

        // full permutation
        i_req = '0;
        i_req[0][1] = 1'b1;
        i_req[1][2] = 1'b1;
        i_req[2][3] = 1'b1;
        i_req[3][4] = 1'b1;
        i_req[4][0] = 1'b1;
        @(negedge clk);
        chk("t4_ack", o_ack, 5'b11111);
        tick();
        i_req = '0;
        @(negedge clk);
        chk("t4_val", o_sel_val, 5'b11111);
        chk("t4_sel0", o_sel[0], 4);
        chk("t4_sel1", o_sel[1], 0);
        chk("t4_sel2", o_sel[2], 1);
        chk("t4_sel3", o_sel[3], 2);
        chk("t4_sel4", o_sel[4], 3);
        tick();

        // pointer wrap on output 1
        i_req[4][1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t6_ack4", o_ack, 5'b00001);
            tick();
        end
        i_req[0][1] = 1'b1;
        @(negedge clk);
        chk("t6_ack0_first", o_ack, 5'b10000);
        tick();
        @(negedge clk);
        chk("t6_ack4_next", o_ack, 5'b00001);
        tick();

        // illegal requests
        i_req = '0;
        i_req[2][2] = 1'b1;
        @(negedge clk);
        chk("t5_ack_uturn", o_ack, 0);
        chk("t5_err_pre", o_err, 0);
        tick();
        i_req = '0;
        i_req[3] = 5'b01010;
        @(negedge clk);
        chk("t5_ack_multi", o_ack, 0);
        chk("t5_err_set", o_err, 1);
        tick();
        i_req = '0;
        i_req[1][0] = 1'b1;
        @(negedge clk);
        chk("t5_ack_legal", o_ack, 5'b01000);
        chk("t5_err_sticky", o_err, 1);
        tick();
        i_req = '0;
        @(negedge clk);
        chk("t5_err_sticky2", o_err, 1);
        tick();

        // reset mid-operation
        for (int i = 0; i < N; i++) if (i != 2) i_req[i][2] = 1'b1;
        tick();
        chk("mr_val_pre", o_sel_val[2], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_val_clr", o_sel_val, 0);
        chk("mr_err_clr", o_err, 0);
        chk("mr_ack", o_ack, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_ack_first", o_ack, 5'b10000);
        tick();
        @(negedge clk);
        chk("mr_ack_second", o_ack, 5'b01000);
        tick();

        i_req = '0;
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
